// File: rtl/ex_multi_pkg.sv
// Shared opcodes and FSM state encoding for the multi-lane execute stage.
package ex_multi_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD   = 3'd1;
  localparam logic [OP_W-1:0] OP_SUB   = 3'd2;
  localparam logic [OP_W-1:0] OP_AND   = 3'd3;
  localparam logic [OP_W-1:0] OP_OR    = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR   = 3'd5;
  localparam logic [OP_W-1:0] OP_SLT   = 3'd6;
  localparam logic [OP_W-1:0] OP_PASSB = 3'd7;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;
endpackage

// File: rtl/ex_multi_lane_alu.sv
// Single-lane combinational ALU; one instance per lane of ex_multi_lane.
module ex_alu
  import ex_multi_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_SLT:   result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_PASSB: result = b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_multi_lane.sv
// N-lane execute stage with self-bypass and intra-bundle RAW splitting.
// Optional EX_MULTI_STATS_EN adds saturating issue/split counters.
module ex_multi_lane
  import ex_multi_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W*LANES-1:0]   in_op,
  input  logic [RA_W*LANES-1:0]   in_rd,
  input  logic [RA_W*LANES-1:0]   in_rs,
  input  logic [RA_W*LANES-1:0]   in_rt,
  input  logic [DATA_W*LANES-1:0] in_a,
  input  logic [DATA_W*LANES-1:0] in_b,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES-1:0]        out_we,
  output logic [RA_W*LANES-1:0]   out_rd,
  output logic [DATA_W*LANES-1:0] out_data
`ifdef EX_MULTI_STATS_EN
  ,
  output logic [31:0]             stat_issued,
  output logic [31:0]             stat_splits
`endif
);

  localparam int CW = $clog2(LANES + 1);

  state_t                  state, state_next;
  logic [CW-1:0]           base;
  logic                    release_pend;
  logic [OP_W*LANES-1:0]   held_op;
  logic [RA_W*LANES-1:0]   held_rd, held_rs, held_rt;
  logic [DATA_W*LANES-1:0] held_a, held_b;

  logic [OP_W-1:0]   op_l  [LANES];
  logic [RA_W-1:0]   rd_l  [LANES];
  logic [RA_W-1:0]   rs_l  [LANES];
  logic [RA_W-1:0]   rt_l  [LANES];
  logic [DATA_W-1:0] opa   [LANES];
  logic [DATA_W-1:0] opb   [LANES];
  logic [DATA_W-1:0] alu_res [LANES];

  logic [LANES-1:0]        dep, issue_mask, valid_n, we_n;
  logic [RA_W*LANES-1:0]   rd_n;
  logic [DATA_W*LANES-1:0] data_n;
  logic                    issue_en, latch;
  int                      first, cut;

  // Operand select and bypass; the youngest matching previous-cycle writer wins.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      op_l[k] = (state == ST_SPLIT) ? held_op[k*OP_W +: OP_W] : in_op[k*OP_W +: OP_W];
      rd_l[k] = (state == ST_SPLIT) ? held_rd[k*RA_W +: RA_W] : in_rd[k*RA_W +: RA_W];
      rs_l[k] = (state == ST_SPLIT) ? held_rs[k*RA_W +: RA_W] : in_rs[k*RA_W +: RA_W];
      rt_l[k] = (state == ST_SPLIT) ? held_rt[k*RA_W +: RA_W] : in_rt[k*RA_W +: RA_W];
      opa[k]  = (state == ST_SPLIT) ? held_a[k*DATA_W +: DATA_W] : in_a[k*DATA_W +: DATA_W];
      opb[k]  = (state == ST_SPLIT) ? held_b[k*DATA_W +: DATA_W] : in_b[k*DATA_W +: DATA_W];
      for (int j = 0; j < LANES; j++) begin
        if (out_we[j] && out_rd[j*RA_W +: RA_W] == rs_l[k]) opa[k] = out_data[j*DATA_W +: DATA_W];
        if (out_we[j] && out_rd[j*RA_W +: RA_W] == rt_l[k]) opb[k] = out_data[j*DATA_W +: DATA_W];
      end
      if (rs_l[k] == '0) opa[k] = '0;
      if (rt_l[k] == '0) opb[k] = '0;
    end
  end

  genvar g;
  for (g = 0; g < LANES; g++) begin : g_lane
    ex_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (op_l[g]),
      .a      (opa[g]),
      .b      (opb[g]),
      .result (alu_res[g])
    );
  end

  // Hazard priority encoder over the pending slice, FSM next state and output values.
  always_comb begin
    first = (state == ST_SPLIT) ? int'(base) : 0;
    for (int k = 0; k < LANES; k++) begin
      dep[k] = 1'b0;
      for (int j = 0; j < LANES; j++) begin
        if (j < k && j >= first && op_l[j] != OP_NOP && op_l[k] != OP_NOP && rd_l[j] != '0 &&
            (rd_l[j] == rs_l[k] || rd_l[j] == rt_l[k]))
          dep[k] = 1'b1;
      end
    end
    cut = LANES;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (dep[k]) cut = k;
    end

    issue_en   = (state == ST_SPLIT) || (in_valid && !release_pend);
    latch      = (state == ST_ISSUE) && issue_en && (cut != LANES);
    in_ready   = (state == ST_ISSUE) && (release_pend || !in_valid || cut == LANES);
    state_next = state;
    if (state == ST_ISSUE && latch) state_next = ST_SPLIT;
    if (state == ST_SPLIT && cut == LANES) state_next = ST_ISSUE;

    valid_n = '0;
    we_n    = '0;
    rd_n    = '0;
    data_n  = '0;
    for (int k = 0; k < LANES; k++) begin
      issue_mask[k] = issue_en && (k >= first) && (k < cut);
      if (issue_mask[k]) begin
        valid_n[k]                 = 1'b1;
        we_n[k]                    = (rd_l[k] != '0) && (op_l[k] != OP_NOP);
        rd_n[k*RA_W +: RA_W]       = rd_l[k];
        data_n[k*DATA_W +: DATA_W] = alu_res[k];
      end
    end
  end

  // After a split completes, the still-presented bundle is acknowledged without re-issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_ISSUE;
      base         <= '0;
      release_pend <= 1'b0;
      held_op      <= '0;
      held_rd      <= '0;
      held_rs      <= '0;
      held_rt      <= '0;
      held_a       <= '0;
      held_b       <= '0;
      out_valid    <= '0;
      out_we       <= '0;
      out_rd       <= '0;
      out_data     <= '0;
    end else begin
      state        <= state_next;
      release_pend <= (state == ST_SPLIT) && (cut == LANES);
      if (latch) begin
        held_op <= in_op;
        held_rd <= in_rd;
        held_rs <= in_rs;
        held_rt <= in_rt;
        held_a  <= in_a;
        held_b  <= in_b;
      end
      if (state_next == ST_SPLIT) base <= CW'(cut);
      out_valid <= valid_n;
      out_we    <= we_n;
      out_rd    <= rd_n;
      out_data  <= data_n;
    end
  end

`ifdef EX_MULTI_STATS_EN
  logic [32:0] issued_sum;
  int          n_issued;

  always_comb begin
    n_issued = 0;
    for (int k = 0; k < LANES; k++) begin
      if (issue_mask[k] && op_l[k] != OP_NOP) n_issued = n_issued + 1;
    end
    issued_sum = {1'b0, stat_issued} + 33'(n_issued);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_issued <= '0;
      stat_splits <= '0;
    end else begin
      stat_issued <= issued_sum[32] ? '1 : issued_sum[31:0];
      if (state == ST_SPLIT && stat_splits != '1) stat_splits <= stat_splits + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_multi_lane.sv
// Scoreboard bench for ex_multi_lane: a 2-lane and a 4-lane instance.
// Stats checks are compiled in when EX_MULTI_STATS_EN is defined.
module tb_ex_multi_lane;
  import ex_multi_pkg::*;

  typedef struct packed {
    logic [3:0]   valid;
    logic [3:0]   we;
    logic [19:0]  rd;
    logic [127:0] data;
  } exp_t;

  logic clk, reset;

  logic        in_valid2, in_ready2;
  logic [5:0]  in_op2;
  logic [9:0]  in_rd2, in_rs2, in_rt2;
  logic [63:0] in_a2, in_b2;
  logic [1:0]  out_valid2, out_we2;
  logic [9:0]  out_rd2;
  logic [63:0] out_data2;

  logic         in_valid4, in_ready4;
  logic [11:0]  in_op4;
  logic [19:0]  in_rd4, in_rs4, in_rt4;
  logic [127:0] in_a4, in_b4;
  logic [3:0]   out_valid4, out_we4;
  logic [19:0]  out_rd4;
  logic [127:0] out_data4;

`ifdef EX_MULTI_STATS_EN
  logic [31:0] stat_issued2, stat_splits2, stat_issued4, stat_splits4;
`endif

  exp_t q2[$];
  exp_t q4[$];
  exp_t e2, e4;
  int compared = 0;
  int mismatched = 0;

  ex_multi_lane #(.LANES(2), .DATA_W(32), .RA_W(5)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_op(in_op2), .in_rd(in_rd2), .in_rs(in_rs2), .in_rt(in_rt2),
    .in_a(in_a2), .in_b(in_b2), .out_valid(out_valid2), .out_we(out_we2),
    .out_rd(out_rd2), .out_data(out_data2)
`ifdef EX_MULTI_STATS_EN
    , .stat_issued(stat_issued2), .stat_splits(stat_splits2)
`endif
  );

  ex_multi_lane #(.LANES(4), .DATA_W(32), .RA_W(5)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_op(in_op4), .in_rd(in_rd4), .in_rs(in_rs4), .in_rt(in_rt4),
    .in_a(in_a4), .in_b(in_b4), .out_valid(out_valid4), .out_we(out_we4),
    .out_rd(out_rd4), .out_data(out_data4)
`ifdef EX_MULTI_STATS_EN
    , .stat_issued(stat_issued4), .stat_splits(stat_splits4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] dmask(input logic [3:0] v);
    logic [127:0] r = '0;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = {32{v[k]}};
    return r;
  endfunction

  function automatic logic [19:0] rmask(input logic [3:0] v);
    logic [19:0] r = '0;
    for (int k = 0; k < 4; k++) r[k*5 +: 5] = {5{v[k]}};
    return r;
  endfunction

  function automatic exp_t mk2(input logic [1:0] v, input logic [1:0] w, input logic [4:0] rd1,
                               input logic [4:0] rd0, input logic [31:0] d1, input logic [31:0] d0);
    exp_t e = '0;
    e.valid = {2'b00, v};
    e.we    = {2'b00, w};
    e.rd    = {10'd0, rd1, rd0};
    e.data  = {64'd0, d1, d0};
    return e;
  endfunction

  function automatic exp_t mk4(input int k, input logic [4:0] rd, input logic [31:0] d);
    exp_t e = '0;
    e.valid[k]         = 1'b1;
    e.we[k]            = 1'b1;
    e.rd[k*5 +: 5]     = rd;
    e.data[k*32 +: 32] = d;
    return e;
  endfunction

  task automatic set_lane2(input int k, input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [31:0] a, input logic [31:0] b);
    in_op2[k*3 +: 3] = op;
    in_rd2[k*5 +: 5] = rd;
    in_rs2[k*5 +: 5] = rs;
    in_rt2[k*5 +: 5] = rt;
    in_a2[k*32 +: 32] = a;
    in_b2[k*32 +: 32] = b;
  endtask

  task automatic set_lane4(input int k, input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [31:0] a, input logic [31:0] b);
    in_op4[k*3 +: 3] = op;
    in_rd4[k*5 +: 5] = rd;
    in_rs4[k*5 +: 5] = rs;
    in_rt4[k*5 +: 5] = rt;
    in_a4[k*32 +: 32] = a;
    in_b4[k*32 +: 32] = b;
  endtask

  // Present the staged bundle, wait (bounded) for in_ready, and count stall cycles.
  task automatic apply_stimulus(input int sel, input string name, input int exp_stalls);
    int n = 0;
    if (sel == 2) in_valid2 = 1'b1; else in_valid4 = 1'b1;
    @(negedge clk);
    while (!((sel == 2) ? in_ready2 : in_ready4) && n < 10) begin
      n++;
      @(negedge clk);
    end
    check_output(name, 128'(n), 128'(exp_stalls));
    @(posedge clk);
    #1;
    if (sel == 2) in_valid2 = 1'b0; else in_valid4 = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop and compare whenever a DUT presents any valid lane.
  always @(negedge clk) begin
    if (!reset && out_valid2 != '0) begin
      if (q2.size() == 0) check_output("dut2_unexpected_out", 128'(out_valid2), 128'(0));
      else begin
        e2 = q2.pop_front();
        check_output("dut2_valid", 128'(out_valid2), 128'(e2.valid));
        check_output("dut2_we", 128'(out_we2), 128'(e2.we));
        check_output("dut2_rd", 128'(20'(out_rd2) & rmask(e2.valid)), 128'(e2.rd & rmask(e2.valid)));
        check_output("dut2_data", 128'(out_data2) & dmask(e2.valid), e2.data & dmask(e2.valid));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid4 != '0) begin
      if (q4.size() == 0) check_output("dut4_unexpected_out", 128'(out_valid4), 128'(0));
      else begin
        e4 = q4.pop_front();
        check_output("dut4_valid", 128'(out_valid4), 128'(e4.valid));
        check_output("dut4_we", 128'(out_we4), 128'(e4.we));
        check_output("dut4_rd", 128'(out_rd4 & rmask(e4.valid)), 128'(e4.rd & rmask(e4.valid)));
        check_output("dut4_data", out_data4 & dmask(e4.valid), e4.data & dmask(e4.valid));
      end
    end
  end

  initial begin
    reset = 1'b1;
    in_valid2 = 1'b0; in_op2 = '0; in_rd2 = '0; in_rs2 = '0; in_rt2 = '0; in_a2 = '0; in_b2 = '0;
    in_valid4 = 1'b0; in_op4 = '0; in_rd4 = '0; in_rs4 = '0; in_rt4 = '0; in_a4 = '0; in_b4 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("reset_out_valid2", 128'(out_valid2), 128'(0));
    check_output("reset_out_data2", 128'(out_data2), 128'(0));
    check_output("reset_in_ready2", 128'(in_ready2), 128'(1));
    check_output("reset_out_valid4", 128'(out_valid4), 128'(0));
    idle();

    // Independent lanes, then a back-to-back consumer of r3/r4 via bypass.
    set_lane2(0, OP_ADD, 5'd3, 5'd1, 5'd2, 32'd0, 32'd1);
    set_lane2(1, OP_ADD, 5'd4, 5'd5, 5'd6, 32'd2, 32'd3);
    q2.push_back(mk2(2'b11, 2'b11, 5'd4, 5'd3, 32'd5, 32'd1));
    apply_stimulus(2, "indep_stalls", 0);
    set_lane2(0, OP_ADD, 5'd5, 5'd3, 5'd0, 32'd100, 32'd50);
    set_lane2(1, OP_SUB, 5'd6, 5'd4, 5'd1, 32'd0, 32'd2);
    q2.push_back(mk2(2'b11, 2'b11, 5'd6, 5'd5, 32'd3, 32'd1));
    apply_stimulus(2, "bypass_stalls", 0);
    idle();

    // Intra-bundle RAW: lane1 reads r3 from lane0, stale operands ignored.
    set_lane2(0, OP_ADD, 5'd3, 5'd1, 5'd2, 32'd1, 32'd1);
    set_lane2(1, OP_ADD, 5'd4, 5'd3, 5'd3, 32'd9, 32'd9);
    q2.push_back(mk2(2'b01, 2'b01, 5'd0, 5'd3, 32'd0, 32'd2));
    q2.push_back(mk2(2'b10, 2'b10, 5'd4, 5'd0, 32'd4, 32'd0));
    apply_stimulus(2, "split_stalls", 2);

    // WAW on r3, then the youngest writer is forwarded.
    set_lane2(0, OP_PASSB, 5'd3, 5'd0, 5'd1, 32'd0, 32'd7);
    set_lane2(1, OP_PASSB, 5'd3, 5'd0, 5'd2, 32'd0, 32'd9);
    q2.push_back(mk2(2'b11, 2'b11, 5'd3, 5'd3, 32'd9, 32'd7));
    apply_stimulus(2, "waw_stalls", 0);
    set_lane2(0, OP_PASSB, 5'd7, 5'd0, 5'd3, 32'd0, 32'd0);
    set_lane2(1, OP_OR, 5'd8, 5'd3, 5'd3, 32'd0, 32'd0);
    q2.push_back(mk2(2'b11, 2'b11, 5'd8, 5'd7, 32'd9, 32'd9));
    apply_stimulus(2, "waw_fwd_stalls", 0);

    // Arithmetic corners, r0 handling, logic ops and NOP.
    set_lane2(0, OP_SUB, 5'd9, 5'd10, 5'd11, 32'd0, 32'd1);
    set_lane2(1, OP_SLT, 5'd10, 5'd12, 5'd13, 32'h8000_0000, 32'd1);
    q2.push_back(mk2(2'b11, 2'b11, 5'd10, 5'd9, 32'd1, 32'hFFFF_FFFF));
    apply_stimulus(2, "arith_stalls", 0);
    set_lane2(0, OP_ADD, 5'd0, 5'd1, 5'd2, 32'd5, 32'd6);
    set_lane2(1, OP_ADD, 5'd11, 5'd0, 5'd0, 32'd77, 32'd88);
    q2.push_back(mk2(2'b11, 2'b10, 5'd11, 5'd0, 32'd0, 32'd11));
    apply_stimulus(2, "r0_stalls", 0);
    set_lane2(0, OP_XOR, 5'd12, 5'd1, 5'd2, 32'h0000_F0F0, 32'h0000_FF00);
    set_lane2(1, OP_NOP, 5'd13, 5'd0, 5'd0, 32'd5, 32'd5);
    q2.push_back(mk2(2'b11, 2'b01, 5'd13, 5'd12, 32'd0, 32'h0000_0FF0));
    apply_stimulus(2, "xor_nop_stalls", 0);
    set_lane2(0, OP_AND, 5'd14, 5'd1, 5'd2, 32'h0000_FF0F, 32'h0000_0FF0);
    set_lane2(1, OP_OR, 5'd15, 5'd3, 5'd4, 32'h10, 32'h01);
    q2.push_back(mk2(2'b11, 2'b11, 5'd15, 5'd14, 32'h11, 32'h0000_0F00));
    apply_stimulus(2, "and_or_stalls", 0);
    idle();

    // Reset while the 2-lane instance is mid-split abandons lane1.
    set_lane2(0, OP_ADD, 5'd3, 5'd1, 5'd2, 32'd1, 32'd1);
    set_lane2(1, OP_ADD, 5'd4, 5'd3, 5'd3, 32'd9, 32'd9);
    q2.push_back(mk2(2'b01, 2'b01, 5'd0, 5'd3, 32'd0, 32'd2));
    in_valid2 = 1'b1;
    @(negedge clk);
    check_output("split_in_ready_lo", 128'(in_ready2), 128'(0));
    @(negedge clk);
    #1 reset = 1'b1;
    in_valid2 = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    idle();
    @(negedge clk);
    check_output("rst_split_out_valid2", 128'(out_valid2), 128'(0));
    check_output("rst_split_in_ready2", 128'(in_ready2), 128'(1));
    idle();

    // Fully serial 4-lane chain: one lane per cycle, each bypassed from the previous.
    set_lane4(0, OP_ADD, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1);
    set_lane4(1, OP_ADD, 5'd2, 5'd1, 5'd1, 32'd0, 32'd0);
    set_lane4(2, OP_ADD, 5'd3, 5'd2, 5'd2, 32'd0, 32'd0);
    set_lane4(3, OP_ADD, 5'd4, 5'd3, 5'd3, 32'd0, 32'd0);
    q4.push_back(mk4(0, 5'd1, 32'd2));
    q4.push_back(mk4(1, 5'd2, 32'd4));
    q4.push_back(mk4(2, 5'd3, 32'd8));
    q4.push_back(mk4(3, 5'd4, 32'd16));
    apply_stimulus(4, "chain4_stalls", 4);
`ifdef EX_MULTI_STATS_EN
    check_output("stat_splits4", 128'(stat_splits4), 128'(3));
    check_output("stat_issued4", 128'(stat_issued4), 128'(4));
`endif
    idle();

    // Reset with two lanes of the chain still pending.
    q4.push_back(mk4(0, 5'd1, 32'd2));
    q4.push_back(mk4(1, 5'd2, 32'd4));
    in_valid4 = 1'b1;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    in_valid4 = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    idle();
    @(negedge clk);
    check_output("rst_split_out_valid4", 128'(out_valid4), 128'(0));
    check_output("rst_split_in_ready4", 128'(in_ready4), 128'(1));
`ifdef EX_MULTI_STATS_EN
    check_output("stat_splits4_cleared", 128'(stat_splits4), 128'(0));
`endif

    repeat (3) idle();
    check_output("q2_drained", 128'(q2.size()), 128'(0));
    check_output("q4_drained", 128'(q4.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
